// File: rtl/lsu.sv
// Load/store unit for the memory-access stage of the multi-cycle core.
// One load or store is accepted per request while idle. Loads return
// sign/zero-extended data on rdata_o. Word stores write directly. Byte and
// halfword stores are done as a read-modify-write of the containing word.
// A per-transaction timeout aborts any RAM access that is never acknowledged.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   req_i, we_i          start request (sampled in IDLE); 1 = store
//   funct3_i             width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr_i, wdata_i      byte address and store data
//   busy_o, done_o       busy outside IDLE; one-cycle completion pulse
//   rdata_o              extended load result, held until the next good load
//   misalign_o           error pulse with done_o: misaligned or illegal code
//   timeout_o            error pulse with done_o: no acknowledge in time
//   mem_req_o, mem_we_o  RAM request (held until ack) and write enable
//   mem_addr_o           word-aligned RAM address
//   mem_wdata_o          full word to write
//   mem_rdata_i          RAM read word, valid with mem_ack_i
//   mem_ack_i            RAM completion
module lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Load codes 011/11x and store codes other than 000/001/010 are illegal.
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        logic r;
        if (we) begin
            r = f3[2] | (f3[1:0] == 2'b11);
        end else begin
            r = (f3 == 3'b011) | (f3[2:1] == 2'b11);
        end
        return r;
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) & lo[0]) | ((f3[1:0] == 2'b10) & (lo != 2'b00));
    endfunction

    // Select the addressed lane of the read word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Insert the low byte/half of the store data into the read word.
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        case (f3[1:0])
            2'b00: r[{lo, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lo[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    lo_q, lo_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mis_q, mis_d;
    logic          to_q, to_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mreq_q, mreq_d;
    logic          mwe_q, mwe_d;
    logic [31:0]   maddr_q, maddr_d;
    logic [31:0]   mwdata_q, mwdata_d;

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        lo_d     = lo_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        mis_d    = 1'b0;
        to_d     = 1'b0;
        rdata_d  = rdata_q;
        mreq_d   = mreq_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    f3_d    = funct3_i;
                    lo_d    = addr_i[1:0];
                    wdata_d = wdata_i;
                    maddr_d = {addr_i[31:2], 2'b00};
                    cnt_d   = CNT_ZERO;
                    if (is_illegal(we_i, funct3_i) || is_misaligned(funct3_i, addr_i[1:0])) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                    end else if (we_i && (funct3_i == 3'b010)) begin
                        state_d  = WR;
                        mreq_d   = 1'b1;
                        mwe_d    = 1'b1;
                        mwdata_d = wdata_i;
                    end else begin
                        // Loads and the read half of SB/SH.
                        state_d = RD;
                        mreq_d  = 1'b1;
                        mwe_d   = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (mem_ack_i) begin
                    if (we_q) begin
                        // Request stays high; only the write enable flips.
                        state_d  = WR;
                        mwe_d    = 1'b1;
                        cnt_d    = CNT_ZERO;
                        mwdata_d = store_merge(f3_q, lo_q, mem_rdata_i, wdata_q);
                    end else begin
                        state_d = DONE;
                        mreq_d  = 1'b0;
                        rdata_d = load_extend(f3_q, lo_q, mem_rdata_i);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    mreq_d  = 1'b0;
                    to_d    = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WR: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    to_d    = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                mreq_d  = 1'b0;
                mwe_d   = 1'b0;
            end
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            lo_q     <= 2'b00;
            wdata_q  <= 32'd0;
            cnt_q    <= CNT_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
            rdata_q  <= 32'd0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= 32'd0;
            mwdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            lo_q     <= lo_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mis_q    <= mis_d;
            to_q     <= to_d;
            rdata_q  <= rdata_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign misalign_o  = mis_q;
    assign timeout_o   = to_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mreq_q;
    assign mem_we_o    = mwe_q;
    assign mem_addr_o  = maddr_q;
    assign mem_wdata_o = mwdata_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the multi-cycle core, sitting directly downstream of `control` in the memory-access stage. It takes one load or store request per instruction, performs the word-aligned RAM transaction(s), and returns either sign/zero-extended load data for write-back or completion of a store. Sub-word stores are done as read-modify-write. A per-transaction timeout covers RAM that never acknowledges.

## Interface
- `TIMEOUT`, default 16: maximum cycles `mem_req_o` may stay high without `mem_ack_i` before the transaction aborts.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  start request; sampled only in IDLE.
- `we_i`  in  1  1 = store, 0 = load.
- `funct3_i`  in  3  width/sign code:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
- `addr_i`  in  32  byte address (ALU result).
- `wdata_i`  in  32  store data; the low byte or halfword is used for SB/SH.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  extended load result; held until the next successful load.
- `misalign_o`  out  1  one-cycle pulse, coincident with `done_o`: misaligned address or illegal `funct3_i`.
- `timeout_o`  out  1  one-cycle pulse, coincident with `done_o`: no acknowledge within `TIMEOUT` cycles.
- `mem_req_o`  out  1  RAM request; held high until acknowledged.
- `mem_we_o`  out  1  RAM write enable; valid while `mem_req_o` is high.
- `mem_addr_o`  out  32  word address (`addr[31:2]`, 2'b00).
- `mem_wdata_o`  out  32  full word to write.
- `mem_rdata_i`  in  32  RAM read word; valid in the cycle `mem_ack_i` is high.
- `mem_ack_i`  in  1  RAM completion; meaningful only while `mem_req_o` is high.

## Operation
- **Registered outputs.** All outputs come from registers.
- **Reset values.** Every output resets to 0, including `rdata_o`. State resets to IDLE and the timeout counter to 0.
- **States:** IDLE, RD, WR, DONE.
- **IDLE, on `req_i`:**
  - Latch `we_i`, `funct3_i`, `addr_i` and `wdata_i`.
  - Illegal code → DONE with the misalign flag set. Illegal means a load with 011, 110 or 111, or a store with any code other than 000/001/010.
  - Misaligned → DONE with the misalign flag set. Misaligned means LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - Load → RD.
  - SW → WR, with `mem_wdata_o` = `wdata_i`.
  - SB/SH → RD (read half of the read-modify-write).
- **RD:** `mem_req_o`=1, `mem_we_o`=0.
  - On `mem_ack_i`, for a load: select the byte lane `addr[1:0]` or halfword lane `addr[1]`, extend it (sign for LB/LH, zero for LBU/LHU, unchanged for LW), write it to `rdata_o`, then go to DONE.
  - On `mem_ack_i`, for SB/SH: merge the `wdata_i` byte/half into the read word at the addressed lane, write the result to `mem_wdata_o`, then go to WR.
- **WR:** `mem_req_o`=1, `mem_we_o`=1. On `mem_ack_i` go to DONE.
- **DONE:** `done_o`=1 for exactly one cycle, together with any error flag, then go to IDLE. `busy_o` is high in DONE.
- **Timeout counter:**
  - Clears on entry to RD or WR and increments each cycle `mem_req_o` is high without an ack.
  - When it reaches `TIMEOUT`, go to DONE with the timeout flag set.
  - `mem_req_o` drops on the next edge and no RAM write is considered complete.
  - `rdata_o` is unchanged.
- **Errors preserve `rdata_o`.** A misalign or timeout never updates `rdata_o`.
- **Request while busy.** `req_i` is ignored outside IDLE; no queueing.
- **Reset mid-operation.** All state and outputs clear immediately and asynchronously. `mem_req_o` falls without waiting for the edge. A partial read-modify-write is abandoned; a store is never issued after reset.

## Timing
- **Request sampling.** `req_i` is sampled at edge E0.
- **Fastest load** (ack in the first request cycle):
  - `mem_req_o` is high in cycle E0–E1 and the ack arrives in that cycle.
  - `rdata_o` is valid and `done_o` is high in cycle E1–E2.
  - Latency is 2 cycles.
- **SW:** 2 cycles at zero wait.
- **SB/SH:** 3 cycles at zero wait. `mem_req_o` goes low for 0 cycles between RD and WR; it stays high with `mem_we_o` toggling 0→1 at the RD→WR edge.
- **Error completion:** a misalign or illegal code completes in 1 cycle. `done_o` and `misalign_o` are high in E0–E1, and no `mem_req_o` is issued.
- **Wait states:** each wait cycle adds one cycle.
- **Timeout completion:** `done_o` appears `TIMEOUT`+1 cycles after the request started.
- **Back-to-back:** the next `req_i` is accepted at the edge that leaves DONE (state IDLE), at the earliest.

## Test plan
- **LB, zero-wait.** Word 0x80_7F_12_34 at 0x100; LB at 0x103 → `rdata_o`=0xFFFFFF80 and `done_o` 2 cycles after the request. LBU at 0x103 → 0x00000080.
- **LH/LW.** LH at 0x102 → 0xFFFF807F. LW at 0x100 with 3 wait states → 0x807F1234 with `done_o` 5 cycles after the request.
- **SB read-modify-write.** Word 0xAABBCCDD; SB 0x11 at 0x101 → one read, then a write of 0xAABB11DD to 0x100; `done_o` after 3 cycles.
- **Errors.**
  - LW at 0x102 → `misalign_o`+`done_o` in 1 cycle, `mem_req_o` never high, `rdata_o` unchanged.
  - Load with `funct3_i`=111 → same response.
  - `mem_ack_i` held low → `timeout_o` after `TIMEOUT`+1 cycles.
- **Reset and busy.** Assert `reset` low mid-WR, between edges → `mem_req_o`, `busy_o` and `rdata_o` go to 0 immediately, no write completes, and the unit returns to IDLE. A `req_i` pulse while busy → ignored.
